dds_spi_sequencer: RTL and testbench

DDS_SPI_SEQUENCER -- requirements
Module: dds_spi_sequencer

---
 rtl/dds_spi_pkg.sv | 25 ++
 rtl/dds_spi_sequencer.sv | 146 ++++++++++++++
 tb/tb_dds_spi_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_spi_pkg.sv
// Shared state encoding, default parameters and helpers for the DDS SPI sequencer.
package dds_spi_pkg;

  localparam int DEF_MAX_BYTES  = 8;
  localparam int DEF_GAP_CYCLES = 4;
  localparam int DEF_UPD_CYCLES = 4;
  localparam int DEF_TIMEOUT    = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_GAP     = 3'd4,
    ST_UPDATE  = 3'd5,
    ST_FINISH  = 3'd6
  } seq_state_t;

  // Requests beyond the payload capacity are truncated rather than rejected.
  function automatic logic [3:0] clamp_nbytes(input logic [3:0] n, input int max_bytes);
    if (int'(n) > max_bytes) return 4'(max_bytes);
    return n;
  endfunction

endpackage

// File: rtl/dds_spi_sequencer.sv
// Sequences one DDS register transaction (instruction byte + payload) through an
// external SPI byte engine, collects the read-back bytes and strobes IO_UPDATE.
module dds_spi_sequencer
  import dds_spi_pkg::*;
#(
  parameter int MAX_BYTES  = DEF_MAX_BYTES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int UPD_CYCLES = DEF_UPD_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic [7:0]             addr,
  input  logic [8*MAX_BYTES-1:0] data,
  input  logic [3:0]             nbytes,
  input  logic                   upd,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [8*MAX_BYTES-1:0] rdata,
  output logic                   spi_start,
  output logic [7:0]             spi_din,
  input  logic [7:0]             spi_dout,
  input  logic                   spi_cs,
  output logic                   io_update
);

  localparam int DW   = 8 * MAX_BYTES;
  localparam int CMAX = (TIMEOUT > GAP_CYCLES) ?
                        ((TIMEOUT > UPD_CYCLES) ? TIMEOUT : UPD_CYCLES) :
                        ((GAP_CYCLES > UPD_CYCLES) ? GAP_CYCLES : UPD_CYCLES);
  localparam int CW   = $clog2(CMAX + 1);

  seq_state_t    state_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] rdata_q;
  logic [3:0]    nleft_q;
  logic          upd_q;
  logic          first_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q, err_q, spi_start_q, io_update_q;
  logic [7:0]    spi_din_q;

  // GAP_CYCLES, UPD_CYCLES and TIMEOUT are all assumed to be at least 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      rdata_q     <= '0;
      nleft_q     <= '0;
      upd_q       <= 1'b0;
      first_q     <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      spi_start_q <= 1'b0;
      io_update_q <= 1'b0;
      spi_din_q   <= '0;
    end else begin
      done_q      <= 1'b0;
      spi_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            spi_din_q   <= addr;
            data_q      <= data;
            nleft_q     <= clamp_nbytes(nbytes, MAX_BYTES);
            upd_q       <= upd;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b1;
            first_q     <= 1'b1;
            spi_start_q <= 1'b1;
            state_q     <= ST_START;
          end
        end
        ST_START: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT_LO;
        end
        ST_WAIT_LO, ST_WAIT_HI: begin
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end else if (state_q == ST_WAIT_LO) begin
            cnt_q <= cnt_q + 1'b1;
            if (!spi_cs) state_q <= ST_WAIT_HI;
          end else if (!spi_cs) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            // Byte complete: the instruction byte's response carries no data.
            if (!first_q) rdata_q <= {rdata_q[DW-9:0], spi_dout};
            first_q <= 1'b0;
            cnt_q   <= '0;
            if (nleft_q != 4'd0) begin
              state_q <= ST_GAP;
            end else if (upd_q) begin
              io_update_q <= 1'b1;
              state_q     <= ST_UPDATE;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end
          end
        end
        ST_GAP: begin
          if (cnt_q == CW'(GAP_CYCLES - 1)) begin
            spi_din_q   <= data_q[DW-1 -: 8];
            data_q      <= {data_q[DW-9:0], 8'h00};
            nleft_q     <= nleft_q - 4'd1;
            spi_start_q <= 1'b1;
            state_q     <= ST_START;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_UPDATE: begin
          if (cnt_q == CW'(UPD_CYCLES - 1)) begin
            io_update_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= ST_FINISH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign spi_start = spi_start_q;
  assign spi_din   = spi_din_q;
  assign io_update = io_update_q;

endmodule

// File: tb/tb_dds_spi_sequencer.sv
// Directed + randomized bench for dds_spi_sequencer with a behavioural SPI byte
// engine and a transaction-level model of the expected bytes and timing.
module tb_dds_spi_sequencer;

  localparam int MAXB = 8;
  localparam int GAP  = 4;
  localparam int UPD  = 4;
  localparam int TMO  = 1024;
  localparam int DW   = 8 * MAXB;

  logic          clk = 1'b0;
  logic          rst, req, upd, spi_cs;
  logic [7:0]    addr, spi_dout;
  logic [DW-1:0] data;
  logic [3:0]    nbytes;
  logic          busy, done, err, spi_start, io_update;
  logic [DW-1:0] rdata;
  logic [7:0]    spi_din;

  dds_spi_sequencer #(
    .MAX_BYTES(MAXB), .GAP_CYCLES(GAP), .UPD_CYCLES(UPD), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .data(data), .nbytes(nbytes),
    .upd(upd), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .spi_start(spi_start), .spi_din(spi_din), .spi_dout(spi_dout),
    .spi_cs(spi_cs), .io_update(io_update)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model state
  bit         stuck = 1'b0;
  int         cs_rise_cyc = 0;
  logic [7:0] mosi_q[$];
  logic [7:0] mosi_end_q[$];
  logic [7:0] resp_q[$];

  // Monitor statistics
  int   n_start, n_done, n_upd, first_start_cyc, done_cyc;
  logic busy_at_done;
  int   gap_q[$];

  // Transaction model
  logic [7:0]    exp_mosi[$];
  logic [7:0]    resp_plan[$];
  logic [DW-1:0] exp_rdata;
  int            exp_n, exp_upd;
  logic [7:0]    p_a;
  logic [DW-1:0] p_d;
  logic [3:0]    p_nb;
  logic          p_u;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    spi_cs = 1'b1;
    spi_dout = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (spi_start === 1'b1 && !stuck && !rst) begin
        mosi_q.push_back(spi_din);
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        spi_cs = 1'b0;
        repeat ($urandom_range(4, 8)) begin @(posedge clk); #1; end
        spi_dout = (resp_q.size() > 0) ? resp_q.pop_front() : 8'($urandom_range(0, 255));
        spi_cs = 1'b1;
        cs_rise_cyc = cyc;
        mosi_end_q.push_back(spi_din);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (spi_start === 1'b1) begin
        if (n_start > 0) gap_q.push_back(cyc - cs_rise_cyc);
        else first_start_cyc = cyc;
        n_start++;
      end
      if (io_update === 1'b1) n_upd++;
      if (done === 1'b1) begin
        n_done++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
    end
  end

  task automatic plan(input logic [7:0] a, input logic [DW-1:0] d, input logic [3:0] nb,
                      input logic u);
    int n;
    n = (int'(nb) > MAXB) ? MAXB : int'(nb);
    exp_mosi.delete();
    resp_plan.delete();
    exp_mosi.push_back(a);
    for (int i = 0; i < n; i++) exp_mosi.push_back(d[DW-1-8*i -: 8]);
    for (int i = 0; i <= n; i++) resp_plan.push_back(8'($urandom_range(0, 255)));
    exp_n = n;
    exp_upd = u ? UPD : 0;
    p_a = a; p_d = d; p_nb = nb; p_u = u;
  endtask

  task automatic arm();
    n_start = 0; n_done = 0; n_upd = 0; busy_at_done = 1'bx;
    mosi_q.delete(); mosi_end_q.delete(); gap_q.delete();
    resp_q = resp_plan;
    exp_rdata = '0;
    for (int i = 1; i <= exp_n; i++) exp_rdata = (exp_rdata << 8) | DW'(resp_plan[i]);
  endtask

  task automatic launch(input bit hold);
    @(posedge clk); #1;
    arm();
    req = 1'b1; addr = p_a; data = p_d; nbytes = p_nb; upd = p_u;
    @(posedge clk);
    @(negedge clk); #1;
    check("accept_busy", busy, 1'b1);
    check("accept_start", spi_start, 1'b1);
    check("accept_din", spi_din, p_a);
    check("accept_err_clr", err, 1'b0);
    check("accept_rdata_clr", rdata, '0);
    if (!hold) begin
      req = 1'b0;
      addr = 8'($urandom);
      data = {$urandom, $urandom};
      nbytes = 4'($urandom);
      upd = 1'($urandom);
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (n_done == 0 && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    check("done_within_budget", (t < 3000), 1'b1);
  endtask

  task automatic check_xfer(input string tag);
    int m;
    check({tag, "_nstart"}, n_start, exp_n + 1);
    check({tag, "_ndone"}, n_done, 1);
    check({tag, "_busy_at_done"}, busy_at_done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_io_update_cycles"}, n_upd, exp_upd);
    check({tag, "_mosi_count"}, mosi_q.size(), exp_mosi.size());
    m = (mosi_q.size() < exp_mosi.size()) ? mosi_q.size() : exp_mosi.size();
    for (int i = 0; i < m; i++) check({tag, "_mosi_byte"}, mosi_q[i], exp_mosi[i]);
    check({tag, "_din_stable_count"}, mosi_end_q.size(), mosi_q.size());
    for (int i = 0; i < mosi_end_q.size() && i < mosi_q.size(); i++)
      check({tag, "_din_stable"}, mosi_end_q[i], mosi_q[i]);
    check({tag, "_rdata"}, rdata, exp_rdata);
    check({tag, "_gap_count"}, gap_q.size(), exp_n);
    for (int i = 0; i < gap_q.size(); i++) check({tag, "_gap_len"}, gap_q[i], GAP + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]    b_a;
    logic [DW-1:0] b_d;
    logic [3:0]    b_nb;
    logic          b_u;
    int            t;

    rst = 1'b1; req = 1'b0; addr = '0; data = '0; nbytes = '0; upd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_spi_start", spi_start, 1'b0);
    check("rst_io_update", io_update, 1'b0);
    check("rst_spi_din", spi_din, 8'h00);
    check("rst_rdata", rdata, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    plan(8'h01, {32'h01020304, $urandom}, 4'd4, 1'b1);
    launch(1'b0); wait_done(); check_xfer("write4_upd");

    plan(8'($urandom), {$urandom, $urandom}, 4'd0, 1'b0);
    launch(1'b0); wait_done(); check_xfer("instr_only");

    plan(8'h81, {$urandom, $urandom}, 4'd2, 1'($urandom));
    resp_plan[1] = 8'hAA;
    resp_plan[2] = 8'h55;
    launch(1'b0); wait_done(); check_xfer("read2");
    check("read2_low16", rdata[15:0], 16'hAA55);

    for (int k = 0; k < 6; k++) begin
      plan(8'($urandom), {$urandom, $urandom}, 4'($urandom_range(0, 15)), 1'($urandom));
      launch(1'b0); wait_done(); check_xfer("random");
    end

    stuck = 1'b1;
    plan(8'($urandom), {$urandom, $urandom}, 4'd3, 1'b1);
    launch(1'b0); wait_done();
    check("tmo_err", err, 1'b1);
    check("tmo_latency", done_cyc - first_start_cyc, TMO + 1);
    check("tmo_nstart", n_start, 1);
    check("tmo_no_io_update", n_upd, 0);
    check("tmo_busy_at_done", busy_at_done, 1'b0);
    repeat (5) @(negedge clk); #1;
    check("tmo_err_held", err, 1'b1);
    stuck = 1'b0;

    plan(8'($urandom), {$urandom, $urandom}, 4'd4, 1'b1);
    launch(1'b0);
    t = 0;
    while (mosi_q.size() < 3 && t < 500) begin @(negedge clk); #1; t++; end
    while (spi_cs !== 1'b0 && t < 500) begin @(negedge clk); #1; t++; end
    check("rst_mid_reached", (t < 500), 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_spi_start", spi_start, 1'b0);
    check("rst_mid_io_update", io_update, 1'b0);
    check("rst_mid_done", done, 1'b0);
    repeat (30) @(negedge clk); #1;
    check("rst_mid_no_done", n_done, 0);
    plan(8'($urandom), {$urandom, $urandom}, 4'd5, 1'b1);
    launch(1'b0); wait_done(); check_xfer("after_rst");

    b_a = 8'($urandom); b_d = {$urandom, $urandom}; b_nb = 4'($urandom_range(1, 8)); b_u = 1'($urandom);
    plan(8'($urandom), {$urandom, $urandom}, 4'd12, 1'b1);
    launch(1'b1);
    addr = b_a; data = b_d; nbytes = b_nb; upd = b_u;
    wait_done(); check_xfer("clamp12");
    check("clamp12_nstart_9", n_start, 9);
    plan(b_a, b_d, b_nb, b_u);
    arm();
    @(negedge clk); #1;
    check("b2b_idle_busy", busy, 1'b0);
    check("b2b_idle_start", spi_start, 1'b0);
    @(negedge clk); #1;
    check("b2b_busy", busy, 1'b1);
    check("b2b_start", spi_start, 1'b1);
    check("b2b_din", spi_din, b_a);
    req = 1'b0;
    wait_done(); check_xfer("b2b_second");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
